// File: rtl/serial_work_transmit_pkg.sv
// -----------------------------------------------------------------------------
// serial_work_transmit_pkg
//   Shared constants for the work-packet serialiser.
//   - Packet geometry: 672-bit packet made of 84 bytes.
//   - Field MSB offsets inside the packet, ordered {target, data3, data2, data1}.
//   - 3-bit FSM state encoding used by serial_work_transmit.
// -----------------------------------------------------------------------------
package serial_work_transmit_pkg;

    localparam int WORK_PACKET_BITS  = 672;
    localparam int WORK_PACKET_BYTES = 84;

    // Field MSB positions; each field ends one bit above the next field's MSB.
    localparam int TARGET_MSB = 671;
    localparam int DATA3_MSB  = 639;
    localparam int DATA2_MSB  = 511;
    localparam int DATA1_MSB  = 255;

    // Seven bits cover 0..84, which includes the optional checksum slot.
    localparam int BYTE_CNT_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_WAIT_FIN = 3'd4,
        ST_GAP      = 3'd5,
        ST_DONE     = 3'd6
    } tx_state_e;

endpackage

// File: rtl/serial_work_transmit.sv
// -----------------------------------------------------------------------------
// serial_work_transmit
//   Serialises one 84-byte work packet {target, data3, data2, data1} into
//   bytes for an external uart_transmitter, most significant byte first.
//   Handshake per byte: tx_start strobe with tx_byte valid, wait for tx_ready
//   to fall (byte taken), then rise (byte finished), then an optional gap.
//
//   Build option: define SERIAL_WORK_CHECKSUM_EN to append an 85th byte that
//   is the XOR of all 84 packet bytes; tx_done then follows that byte.
//
// Parameters
//   PACKET_BYTES  bytes per packet (fixed by the 672-bit format)
//   GAP_CYCLES    idle clocks between a finished byte and the next tx_start
//
// Ports
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   send      in   one-cycle request, accepted only when idle
//   target    in   packet bits 671:640 (sent first)
//   data3     in   packet bits 639:512
//   data2     in   packet bits 511:256
//   data1     in   packet bits 255:0 (sent last)
//   busy      out  high while a packet is in flight
//   tx_done   out  one-cycle pulse after the final byte completes
//   tx_start  out  one-cycle strobe to the UART transmitter
//   tx_byte   out  byte to transmit, held until the next byte is loaded
//   tx_ready  in   UART transmitter idle/ready
// -----------------------------------------------------------------------------
module serial_work_transmit
    import serial_work_transmit_pkg::*;
#(
    parameter int PACKET_BYTES = WORK_PACKET_BYTES,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            send,
    input  logic [TARGET_MSB-DATA3_MSB-1:0] target,
    input  logic [DATA3_MSB-DATA2_MSB-1:0]  data3,
    input  logic [DATA2_MSB-DATA1_MSB-1:0]  data2,
    input  logic [DATA1_MSB:0]              data1,
    output logic                            busy,
    output logic                            tx_done,
    output logic                            tx_start,
    output logic [7:0]                      tx_byte,
    input  logic                            tx_ready
);

`ifdef SERIAL_WORK_CHECKSUM_EN
    // Checksum occupies index PACKET_BYTES, after the last packet byte.
    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(PACKET_BYTES);
`else
    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(PACKET_BYTES - 1);
`endif

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e                     state_q, state_d;
    logic [WORK_PACKET_BITS-1:0]   shift_q;
    logic [BYTE_CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]              gap_cnt_q;
    logic [7:0]                    tx_byte_q;
    logic                          accept;
    logic                          last_byte;
    logic                          gap_done;
    logic                          load_byte;
`ifdef SERIAL_WORK_CHECKSUM_EN
    logic [7:0]                    xor_q;
    logic                          is_cksum;
`endif

    assign accept    = (state_q == ST_IDLE) && send;
    assign last_byte = (byte_cnt_q == LAST_IDX);
    assign gap_done  = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
    // The byte is loaded on the edge that enters START so it is already valid
    // during the tx_start strobe cycle.
    assign load_byte = (state_d == ST_START);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from pre-edge values, independent of order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first; every path assigns state_d and byte_cnt_d,
        // so no latch is inferred.
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (send) begin
                    state_d    = ST_WAIT_RDY;
                    byte_cnt_d = '0;
                end
            end
            ST_WAIT_RDY: if (tx_ready) state_d = ST_START;
            ST_START:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (!tx_ready) state_d = ST_WAIT_FIN;
            ST_WAIT_FIN: begin
                if (tx_ready) begin
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = (GAP_CYCLES == 0) ? ST_START : ST_GAP;
                    end
                end
            end
            ST_GAP:  if (gap_done) state_d = ST_START;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SERIAL_WORK_CHECKSUM_EN
    // Decided from the next count so it is right even with no gap state.
    assign is_cksum = (byte_cnt_d == BYTE_CNT_W'(PACKET_BYTES));
`endif

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_byte_q  <= '0;
`ifdef SERIAL_WORK_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            byte_cnt_q <= byte_cnt_d;

            if (accept) begin
                shift_q <= {target, data3, data2, data1};
`ifdef SERIAL_WORK_CHECKSUM_EN
                xor_q   <= '0;
`endif
            end

            if (load_byte) begin
`ifdef SERIAL_WORK_CHECKSUM_EN
                if (is_cksum) begin
                    tx_byte_q <= xor_q;
                end else begin
                    tx_byte_q <= shift_q[TARGET_MSB -: 8];
                    shift_q   <= shift_q << 8;
                    xor_q     <= xor_q ^ shift_q[TARGET_MSB -: 8];
                end
`else
                tx_byte_q <= shift_q[TARGET_MSB -: 8];
                shift_q   <= shift_q << 8;
`endif
            end

            // Counts clocks spent in GAP; cleared everywhere else.
            if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q + 1'b1;
            end else begin
                gap_cnt_q <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign busy     = (state_q != ST_IDLE);
    assign tx_done  = (state_q == ST_DONE);
    assign tx_start = (state_q == ST_START);
    assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_serial_work_transmit.sv
// -----------------------------------------------------------------------------
// tb_serial_work_transmit
//   Bench for serial_work_transmit. A UART model drops tx_ready for a fixed
//   busy time after each tx_start; expected bytes are queued when a packet is
//   sent and popped as tx_start strobes appear.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_work_transmit;
    import serial_work_transmit_pkg::*;

    localparam int GAP         = 2;
    localparam int BYTE_BUSY   = 10;
    localparam int DONE_BUDGET = 4000;
`ifdef SERIAL_WORK_CHECKSUM_EN
    localparam int N_BYTES = WORK_PACKET_BYTES + 1;
`else
    localparam int N_BYTES = WORK_PACKET_BYTES;
`endif

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic         send     = 1'b0;
    logic [31:0]  target   = '0;
    logic [127:0] data3    = '0;
    logic [255:0] data2    = '0;
    logic [255:0] data1    = '0;
    logic         busy;
    logic         tx_done;
    logic         tx_start;
    logic [7:0]   tx_byte;
    logic         tx_ready = 1'b1;

    always #5 clk = ~clk;

    serial_work_transmit #(
        .PACKET_BYTES (WORK_PACKET_BYTES),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .send     (send),
        .target   (target),
        .data3    (data3),
        .data2    (data2),
        .data1    (data1),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         n_start = 0;
    int         n_done  = 0;
    logic [7:0] first_b = '0;
    logic [7:0] last_b  = '0;
    bit         hold_low = 1'b0;
    int         busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // UART model + scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
            tx_ready = !hold_low;
        end else begin
            if (tx_done) n_done++;
            if (tx_start) begin
                if (n_start == 0) first_b = tx_byte;
                last_b = tx_byte;
                n_start++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got byte %0h want none", tx_byte);
                end else begin
                    check("sb_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                end
                busy_cnt = BYTE_BUSY;
                tx_ready = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_ready = !hold_low;
            end else begin
                tx_ready = !hold_low;
            end
        end
    end

    // Advance one clock; land just after the falling edge, after the monitor.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [671:0] pkt);
        target = pkt[671:640];
        data3  = pkt[639:512];
        data2  = pkt[511:256];
        data1  = pkt[255:0];
    endtask

    task automatic push_expected(input logic [671:0] pkt);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < WORK_PACKET_BYTES; i++) begin
            exp_q.push_back(pkt[671 - 8*i -: 8]);
            x ^= pkt[671 - 8*i -: 8];
        end
`ifdef SERIAL_WORK_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Queue expectations, pulse send, and return clocks until the first tx_start.
    task automatic send_packet(input string tag, input logic [671:0] pkt, output int lat);
        n_start = 0;
        n_done  = 0;
        push_expected(pkt);
        set_fields(pkt);
        send = 1'b1;
        step();
        send = 1'b0;
        check({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
        lat = 1;
        while (n_start == 0 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (n_done == 0 && c < DONE_BUDGET) begin
            step();
            c++;
        end
        if (n_done == 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no tx_done want tx_done within %0d cycles", tag, DONE_BUDGET);
        end
    endtask

    task automatic finish_checks(input string tag, input logic [7:0] exp_first, input logic [7:0] exp_last);
        repeat (4) step();
        check({tag, "_starts"}, n_start, N_BYTES);
        check({tag, "_dones"},  n_done, 1);
        check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_first"}, {24'd0, first_b}, {24'd0, exp_first});
        check({tag, "_last"},  {24'd0, last_b},  {24'd0, exp_last});
    endtask

    typedef struct {
        string        name;
        logic [31:0]  target;
        logic [127:0] d3;
        logic [255:0] d2;
        logic [255:0] d1;
        logic [7:0]   first;
        logic [7:0]   last;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [671:0] pack(input vec_t v);
        return {v.target, v.d3, v.d2, v.d1};
    endfunction

    function automatic logic [671:0] inc_packet(input logic [31:0] t);
        logic [671:0] p;
        p = '0;
        p[671:640] = t;
        for (int j = 0; j < 80; j++) p[639 - 8*j -: 8] = 8'(j);
        return p;
    endfunction

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got no finish want finish before 3ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [671:0] p;
        int           lat;
        int           c;
        int           snap;
        int           busy_low;
        bit           p3;
        bit           p83;

        // Vector table; expected first/last bytes are hand-derived.
        p = inc_packet(32'h0000FFFF);
        vecs[0] = '{"inc", p[671:640], p[639:512], p[511:256], p[255:0], 8'h00, 8'h4F};
        vecs[1] = '{"beef", 32'hDEADBEEF, '0, '0, '0, 8'hDE, 8'h00};
        vecs[2] = '{"mix", 32'h12345678, {16{8'h11}}, {32{8'h22}}, {{31{8'h33}}, 8'hAB}, 8'h12, 8'hAB};
        vecs[3] = '{"a5", 32'hA5A5A5A5, {16{8'hA5}}, {32{8'hA5}}, {{31{8'hA5}}, 8'h5A}, 8'hA5, 8'h5A};
`ifdef SERIAL_WORK_CHECKSUM_EN
        // Last byte becomes the XOR checksum of the 84 packet bytes.
        vecs[0].last = 8'h00;
        vecs[1].last = 8'h22;
        vecs[2].last = 8'h90;
        vecs[3].last = 8'hFF;
`endif

        // Reset values.
        repeat (3) step();
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_tx_done",  {31'd0, tx_done},  32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_byte",  {24'd0, tx_byte},  32'd0);
        reset_n = 1'b1;
        repeat (3) step();

        // Table-driven packets.
        for (int v = 0; v < 4; v++) begin
            send_packet(vecs[v].name, pack(vecs[v]), lat);
            check({vecs[v].name, "_lat_ge2"}, {31'd0, lat >= 2}, 32'd1);
            wait_done(vecs[v].name);
            finish_checks(vecs[v].name, vecs[v].first, vecs[v].last);
        end

        // Sends at bytes 3 and 83 ignored; a send coincident with DONE ignored.
        send_packet("ign", pack(vecs[2]), lat);
        p3 = 1'b0;
        p83 = 1'b0;
        c = 0;
        while (!tx_done && c < DONE_BUDGET) begin
            if (n_start == 3 && !p3) begin
                p3 = 1'b1;
                target = 32'hCAFEF00D;
                data1  = '1;
                send = 1'b1;
                step();
                send = 1'b0;
            end else if (n_start == 83 && !p83) begin
                p83 = 1'b1;
                target = 32'h0BADF00D;
                data3  = '1;
                send = 1'b1;
                step();
                send = 1'b0;
            end else begin
                step();
            end
            c++;
        end
        check("ign_in_done", {31'd0, tx_done}, 32'd1);
        target = 32'h55555555;
        send = 1'b1;
        step();
        send = 1'b0;
        snap = n_start;
        repeat (30) step();
        check("ign_done_send_starts", n_start, snap);
        check("ign_done_send_busy", {31'd0, busy}, 32'd0);
        check("ign_starts", n_start, N_BYTES);
        check("ign_sb_empty", exp_q.size(), 0);
        check("ign_last", {24'd0, last_b}, {24'd0, vecs[2].last});

        // Reset during byte 40: async clear, no further strobes, clean restart.
        send_packet("rstmid", pack(vecs[1]), lat);
        c = 0;
        while (n_start < 40 && c < DONE_BUDGET) begin
            step();
            c++;
        end
        check("rstmid_reached", n_start, 40);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_busy",     {31'd0, busy},     32'd0);
        check("rstmid_tx_done",  {31'd0, tx_done},  32'd0);
        check("rstmid_tx_start", {31'd0, tx_start}, 32'd0);
        check("rstmid_tx_byte",  {24'd0, tx_byte},  32'd0);
        exp_q.delete();
        snap = n_start;
        repeat (50) step();
        check("rstmid_no_start", n_start, snap);
        reset_n = 1'b1;
        repeat (3) step();
        check("rstmid_still_idle", n_start, snap);
        send_packet("restart", pack(vecs[0]), lat);
        wait_done("restart");
        finish_checks("restart", vecs[0].first, vecs[0].last);

        // tx_ready held low before the first byte.
        hold_low = 1'b1;
        repeat (2) step();
        send_packet("stuck", pack(vecs[3]), lat);
        busy_low = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (!busy) busy_low++;
        end
        check("stuck_no_start", n_start, 0);
        check("stuck_busy_cycles_low", busy_low, 0);
        hold_low = 1'b0;
        wait_done("stuck");
        finish_checks("stuck", vecs[3].first, vecs[3].last);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
